// File: rtl/led_pattern_engine_if.sv
// Key/LED bundle of the LED pattern engine.
//   key_mode_n : raw mode key, active-low, asynchronous
//   key_hold_n : raw hold key, active-low, asynchronous
//   led_o      : LED drive (N_LED bits)
//   mode_o     : current pattern mode
//   tick_o     : one-cycle pulse when a new step/flash value appears on led_o
// master = board/key side, slave = pattern engine.
interface led_pattern_engine_if #(
   parameter int unsigned N_LED = 6
);
   logic             key_mode_n;
   logic             key_hold_n;
   logic [N_LED-1:0] led_o;
   logic [1:0]       mode_o;
   logic             tick_o;

   modport master (
      output key_mode_n,
      output key_hold_n,
      input  led_o,
      input  mode_o,
      input  tick_o
   );

   modport slave (
      input  key_mode_n,
      input  key_hold_n,
      output led_o,
      output mode_o,
      output tick_o
   );
endinterface

// File: rtl/led_pattern_engine.sv
// LED pattern generator for board bring-up demos.
// Synchronises and debounces two raw keys; the mode key cycles
// FILL -> BOUNCE -> FLASH -> ALL_ON, the hold key freezes the pattern.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of led_pattern_engine_if (keys in, led/mode/tick out)
module led_pattern_engine #(
   parameter int unsigned N_LED           = 6,
   parameter int unsigned STEP_CYCLES     = 10000000,
   parameter int unsigned FLASH_CYCLES    = 5000000,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned ACTIVE_LOW_LED  = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   led_pattern_engine_if.slave bus
);

   localparam int unsigned STEP_W   = $clog2(STEP_CYCLES);
   localparam int unsigned FLASH_W  = $clog2(FLASH_CYCLES);
   localparam int unsigned DEB_W    = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned KEY_MODE = 0;
   localparam int unsigned KEY_HOLD = 1;
   localparam logic [N_LED-1:0] LED_RST =
      (ACTIVE_LOW_LED != 0) ? {N_LED{1'b1}} : {N_LED{1'b0}};

   typedef enum logic [1:0] {
      MODE_FILL   = 2'd0,
      MODE_BOUNCE = 2'd1,
      MODE_FLASH  = 2'd2,
      MODE_ALL_ON = 2'd3
   } mode_e;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   // key path state, index KEY_MODE / KEY_HOLD
   logic [1:0]            sync1_q, sync2_q;
   logic [1:0]            key_stable_q, key_stable_d;
   logic [1:0][DEB_W-1:0] deb_cnt_q, deb_cnt_d;
   logic                  mode_prev_q;
   logic                  mode_press;
   logic                  hold_active;

   // pattern state
   mode_e              mode_q, mode_d;
   dir_e               dir_q, dir_d;
   logic [N_LED-1:0]   pattern_q, pattern_d;
   logic [N_LED-1:0]   led_q, led_d;
   logic [STEP_W-1:0]  step_cnt_q, step_cnt_d;
   logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;
   logic               flash_state_q, flash_state_d;
   logic               tick_q, tick_d;

   // Key synchronisers, debounce counters and previous mode level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q      <= 2'b11;
         sync2_q      <= 2'b11;
         key_stable_q <= 2'b11;
         deb_cnt_q    <= '0;
         mode_prev_q  <= 1'b1;
      end else begin
         sync1_q      <= {bus.key_hold_n, bus.key_mode_n};
         sync2_q      <= sync1_q;
         key_stable_q <= key_stable_d;
         deb_cnt_q    <= deb_cnt_d;
         mode_prev_q  <= key_stable_q[KEY_MODE];
      end
   end

   // Debounce: accept a new level once it has differed for DEBOUNCE_CYCLES edges
   always_comb begin
      key_stable_d = key_stable_q;
      deb_cnt_d    = deb_cnt_q;
      for (int k = 0; k < 2; k++) begin
         if (sync2_q[k] == key_stable_q[k]) begin
            deb_cnt_d[k] = '0;
         end else if (deb_cnt_q[k] == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
            key_stable_d[k] = sync2_q[k];
            deb_cnt_d[k]    = '0;
         end else begin
            deb_cnt_d[k] = deb_cnt_q[k] + DEB_W'(1);
         end
      end
   end

   assign mode_press  = mode_prev_q & ~key_stable_q[KEY_MODE];
   assign hold_active = ~key_stable_q[KEY_HOLD];

   // Pattern state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q        <= MODE_FILL;
         dir_q         <= DIR_UP;
         pattern_q     <= '0;
         led_q         <= LED_RST;
         step_cnt_q    <= '0;
         flash_cnt_q   <= '0;
         flash_state_q <= 1'b0;
         tick_q        <= 1'b0;
      end else begin
         mode_q        <= mode_d;
         dir_q         <= dir_d;
         pattern_q     <= pattern_d;
         led_q         <= led_d;
         step_cnt_q    <= step_cnt_d;
         flash_cnt_q   <= flash_cnt_d;
         flash_state_q <= flash_state_d;
         tick_q        <= tick_d;
      end
   end

   // Mode sequencing and per-mode pattern stepping
   always_comb begin
      mode_d        = mode_q;
      dir_d         = dir_q;
      pattern_d     = pattern_q;
      step_cnt_d    = step_cnt_q;
      flash_cnt_d   = flash_cnt_q;
      flash_state_d = flash_state_q;
      tick_d        = 1'b0;

      if (mode_press) begin
         // a press wins over hold and over a coincident step
         mode_d        = mode_e'(2'(mode_q) + 2'd1);
         dir_d         = DIR_UP;
         step_cnt_d    = '0;
         flash_cnt_d   = '0;
         flash_state_d = 1'b0;
         case (mode_d)
            MODE_FILL:   pattern_d = '0;
            MODE_BOUNCE: pattern_d = N_LED'(1);
            MODE_FLASH:  pattern_d = '0;
            default:     pattern_d = '1;
         endcase
      end else if (!hold_active) begin
         case (mode_q)
            MODE_FILL: begin
               if (step_cnt_q == STEP_W'(STEP_CYCLES - 1)) begin
                  step_cnt_d = '0;
                  tick_d     = 1'b1;
                  if (dir_q == DIR_UP) begin
                     if (&pattern_q) dir_d     = DIR_DOWN;
                     else            pattern_d = (pattern_q << 1) | N_LED'(1);
                  end else begin
                     if (pattern_q == '0) dir_d     = DIR_UP;
                     else                 pattern_d = pattern_q >> 1;
                  end
               end else begin
                  step_cnt_d = step_cnt_q + STEP_W'(1);
               end
            end
            MODE_BOUNCE: begin
               if (step_cnt_q == STEP_W'(STEP_CYCLES - 1)) begin
                  step_cnt_d = '0;
                  tick_d     = 1'b1;
                  // a single LED has nowhere to bounce; it stays lit
                  if (N_LED > 1) begin
                     if (dir_q == DIR_UP) begin
                        if (pattern_q[N_LED-1]) begin
                           dir_d     = DIR_DOWN;
                           pattern_d = pattern_q >> 1;
                        end else begin
                           pattern_d = pattern_q << 1;
                        end
                     end else begin
                        if (pattern_q[0]) begin
                           dir_d     = DIR_UP;
                           pattern_d = pattern_q << 1;
                        end else begin
                           pattern_d = pattern_q >> 1;
                        end
                     end
                  end
               end else begin
                  step_cnt_d = step_cnt_q + STEP_W'(1);
               end
            end
            MODE_FLASH: begin
               if (flash_cnt_q == FLASH_W'(FLASH_CYCLES - 1)) begin
                  flash_cnt_d   = '0;
                  flash_state_d = ~flash_state_q;
                  pattern_d     = flash_state_d ? '1 : '0;
                  tick_d        = 1'b1;
               end else begin
                  flash_cnt_d = flash_cnt_q + FLASH_W'(1);
               end
            end
            default: begin
               pattern_d = '1;
            end
         endcase
      end

      led_d = (ACTIVE_LOW_LED != 0) ? ~pattern_d : pattern_d;
   end

   assign bus.led_o  = led_q;
   assign bus.mode_o = 2'(mode_q);
   assign bus.tick_o = tick_q;

endmodule
